// File: rtl/fetch_sequencer.sv
// fetch_sequencer: one-outstanding-request instruction fetch FSM (imem_req/addr/ack/rdata) handing inst/inst_pc to decode via valid/ready, with branch/zero/imm16/halt next-PC, halted and retire_count
module fetch_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [29:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [29:0]       inst_pc,
    input  logic              inst_ready,
    input  logic              branch,
    input  logic              zero,
    input  logic [15:0]       imm16,
    input  logic              halt,
    output logic              halted,
    output logic [31:0]       retire_count
);
    typedef enum logic [1:0] {IDLE, REQ, VALID, HALTED} state_t;
    state_t      state;
    logic [29:0] pc;
    logic [29:0] next_pc;
    assign imem_addr = pc;
    assign next_pc   = (branch & zero) ? pc + {{14{imm16[15]}}, imm16} : pc + 30'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            inst_valid   <= 1'b0;
            halted       <= 1'b0;
            inst         <= '0;
            inst_pc      <= '0;
            retire_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: if (imem_ack) begin
                    inst       <= imem_rdata;
                    inst_pc    <= pc;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b1;
                    state      <= VALID;
                end
                VALID: if (inst_ready) begin
                    pc           <= next_pc;
                    retire_count <= retire_count + 32'd1;
                    inst_valid   <= 1'b0;
                    imem_req     <= !halt;
                    halted       <= halt;
                    state        <= halt ? HALTED : REQ;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] imm16 = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic [31:0] retire_count;
    typedef struct {
        logic [31:0] data;
        logic [29:0] pc;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int exp_retire = 0;
    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .branch(branch),
        .zero(zero), .imm16(imm16), .halt(halt), .halted(halted), .retire_count(retire_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] mem(input logic [29:0] a);
        return {2'b10, a} ^ 32'h5A5A_C3C3;
    endfunction
    task automatic step(input logic [29:0] addr, input int lat, input int hold,
                        input logic br, input logic z, input logic [15:0] imm, input logic hlt);
        int   n;
        exp_t e;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("req_timeout", 64'(imem_req), 64'd1);
            return;
        end
        chk("imem_addr", 64'(imem_addr), 64'(addr));
        chk("valid_in_req", 64'(inst_valid), 64'd0);
        sb.push_back('{mem(addr), addr});
        inst_ready = 1'b1; branch = 1'b1; zero = 1'b1; halt = 1'b1; imm16 = 16'h1234;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("req_hold", {33'd0, imem_req, imem_addr}, {33'd0, 1'b1, addr});
        end
        imem_ack = 1'b1; imem_rdata = mem(addr);
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; branch = 1'b0; zero = 1'b0; halt = 1'b0; imm16 = '0;
        chk("inst_valid", 64'(inst_valid), 64'd1);
        chk("req_after_ack", 64'(imem_req), 64'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk("inst", 64'(inst), 64'(e.data));
        chk("inst_pc", 64'(inst_pc), 64'(e.pc));
        for (int i = 0; i < hold; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("hold_stable", {30'd0, inst_valid, imem_req, inst}, {30'd0, 1'b1, 1'b0, e.data});
            chk("hold_pc", 64'(inst_pc), 64'(e.pc));
        end
        imem_ack = 1'b0;
        inst_ready = 1'b1; branch = br; zero = z; imm16 = imm; halt = hlt;
        @(negedge clk);
        inst_ready = 1'b0; branch = 1'b0; zero = 1'b0; imm16 = '0; halt = 1'b0;
        exp_retire++;
        chk("retire_count", 64'(retire_count), 64'(exp_retire));
        chk("valid_drop", 64'(inst_valid), 64'd0);
        chk("post_accept", {62'd0, imem_req, halted}, hlt ? 64'd1 : 64'd2);
    endtask
    initial begin
        #1;
        chk("rst_outs", {58'd0, imem_req, inst_valid, halted, 3'd0}, 64'd0);
        chk("rst_inst", {inst, 2'd0, inst_pc}, 64'd0);
        chk("rst_retire", 64'(retire_count), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", 64'(imem_req), 64'd1);
        step(30'h0,          1, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(30'h1,          1, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(30'h2,          3, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(30'h3,          1, 4, 1'b1, 1'b1, 16'h000D, 1'b0);
        step(30'h10,         1, 0, 1'b1, 1'b1, 16'hFFFC, 1'b0);
        step(30'h0C,         2, 0, 1'b1, 1'b0, 16'hFFFC, 1'b0);
        step(30'h0D,         1, 1, 1'b0, 1'b1, 16'h0005, 1'b0);
        step(30'h0E,         1, 0, 1'b1, 1'b1, 16'h0002, 1'b0);
        step(30'h10,         1, 0, 1'b1, 1'b0, 16'hFFFC, 1'b0);
        step(30'h11,         1, 0, 1'b1, 1'b1, 16'hFFEF, 1'b0);
        step(30'h0,          1, 0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        step(30'h3FFF_FFFF,  1, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(30'h0,          1, 0, 1'b1, 1'b1, 16'h8000, 1'b0);
        step(30'h3FFF_8000,  2, 2, 1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1; inst_ready = 1'b1;
            @(negedge clk);
            chk("halted_idle", {61'd0, imem_req, inst_valid, halted}, 64'd1);
        end
        imem_ack = 1'b0; inst_ready = 1'b0;
        chk("halted_retire", 64'(retire_count), 64'(exp_retire));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", {33'd0, imem_req, imem_addr}, {33'd0, 1'b1, 30'h0});
        chk("restart_retire", 64'(retire_count), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", {61'd0, imem_req, inst_valid, halted}, 64'd0);
        chk("async_retire", 64'(retire_count), 64'd0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        rst_n = 1'b1;
        exp_retire = 0;
        step(30'h0, 2, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(30'h1, 1, 0, 1'b0, 1'b0, 16'h0000, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the word-addressed 30-bit program counter and sequences instruction fetch for the core.
- Issues one request at a time to instruction memory and tolerates multi-cycle memory latency.
- Presents each fetched instruction to the decode/execute stage with a valid/ready handshake.
- Computes the next PC from the branch outcome returned when the stage accepts the instruction: sequential `pc+1`, or `pc+sext(imm16)` when taken.

Parameters:
- RESET_PC, 30'h0000_0000, word address loaded into the PC on reset.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  30  word address of the outstanding request
- imem_ack  in  1  memory returns data for the outstanding request this cycle
- imem_rdata  in  INST_W  instruction data, valid when imem_ack=1
- inst_valid  out  1  held instruction available to the consumer
- inst  out  INST_W  held instruction
- inst_pc  out  30  word address of the held instruction
- inst_ready  in  1  consumer accepts the held instruction this cycle
- branch  in  1  accepted instruction is a branch; sampled only on accept
- zero  in  1  ALU zero flag for the accepted instruction; sampled only on accept
- imm16  in  16  branch offset in words, two's complement; sampled only on accept
- halt  in  1  stop fetching after this accept; sampled only on accept
- halted  out  1  sequencer is stopped
- retire_count  out  32  number of accepted instructions, wraps mod 2^32

Behaviour:
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, inst_valid=0, halted=0, inst=0, inst_pc=0, retire_count=0.
  - Reset asserted mid-fetch abandons the outstanding request. Any later imem_ack is ignored until a new REQ.
- States are IDLE, REQ, VALID and HALTED; all outputs are registered.
- IDLE:
  - All outputs idle.
  - Unconditionally moves to REQ on the next edge, so the first request appears in the first cycle after reset release.
- REQ:
  - imem_req=1 and imem_addr=pc; both are held stable until acked.
  - On imem_ack=1: inst<=imem_rdata, inst_pc<=pc, move to VALID.
  - Otherwise stay in REQ; there is no timeout.
- VALID:
  - inst_valid=1; inst and inst_pc are held stable until accept; imem_req=0.
  - Accept is `inst_valid && inst_ready`. On accept:
    - taken = branch & zero.
    - pc <= taken ? pc + sext30(imm16) : pc + 1.
    - retire_count <= retire_count + 1.
    - If halt=1, move to HALTED; otherwise move to REQ.
- HALTED:
  - halted=1; imem_req=0, inst_valid=0.
  - pc holds the already-computed next PC.
  - Only reset exits this state.
- Arithmetic:
  - sext30 replicates imm16[15] into bits 29:16.
  - All PC sums are modulo 2^30: 30'h3FFF_FFFF+1 = 0; pc=0 with imm16=16'hFFFF gives 30'h3FFF_FFFF.
  - The branch target is relative to the branch's own PC, not to pc+1.
- Timing:
  - Best case is 2 cycles per instruction (ack in the first REQ cycle, ready in the first VALID cycle).
  - Exactly one request is outstanding at any time.
- Ignored inputs:
  - imem_ack outside REQ has no effect.
  - inst_ready, branch, zero, imm16 and halt outside VALID have no effect.
  - branch=1 with zero=0 is sequential.
  - zero=1 with branch=0 is sequential.

Test Plan:
- Reset release, memory always acks, consumer always ready → imem_addr sequence 0,1,2,3 on every second cycle; retire_count increments by 1 per accept.
- Memory acks 3 cycles after each request → imem_req held 3 cycles with imem_addr constant; inst_valid rises the cycle after the ack.
- Consumer holds inst_ready=0 for 4 cycles → inst and inst_pc stable, no new request issued; on ready, the next request appears the following cycle.
- Accept at pc=30'h10 with branch=1, zero=1, imm16=16'hFFFC → next imem_addr=30'h0C. Repeat with zero=0 → next imem_addr=30'h11.
- pc=30'h3FFF_FFFF sequential accept → next imem_addr=0. Separately, pc=0, taken branch, imm16=16'h8000 → next imem_addr=30'h3FFF_8000.
- Accept with halt=1 → halted=1, no further imem_req; rst_n pulsed low during REQ → imem_req drops immediately, and after release fetch restarts at RESET_PC with retire_count=0.
